event_record_reader: RTL and testbench

Consumer end of the event tagger record stream. It captures each 47-bit time-tag record offered with a one-cycle `ready` strobe and buffers it in a small FIFO. It then serializes each record into three 16-bit words for the host-side transfer interface, using a valid/acknowledge handshake. It sits between the event tagger and the host FIFO/USB bridge, runs on the tagger's clock, and flags any records lost to overflow.

---
 rtl/event_record_reader.sv | 142 ++++++++++++++
 tb/tb_event_record_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/event_record_reader.sv
// Captures 47-bit tagger records into a FIFO and serializes each one as three 16-bit words
// over a valid/ack handshake. Overflowed records are counted and marked on the next accepted one.
module event_record_reader #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [46:0]   data_in,
   input  logic          ready_in,
   output logic [15:0]   out_word,
   output logic          out_valid,
   input  logic          out_ack,
   input  logic          clear_status,
   output logic          overflow,
   output logic [15:0]   drop_count,
   output logic [LW-1:0] fifo_level
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StW0, StW1, StW2} state_e;

   state_e          state_q, state_d;
   logic [47:0]     mem [DEPTH];
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [LW-1:0]   level_q, level_d;
   logic [47:0]     entry_q, entry_d;
   logic [15:0]     word_q, word_d;
   logic            valid_q, valid_d;
   logic            lost_q, lost_d;
   logic            overflow_q, overflow_d;
   logic [15:0]     drop_q, drop_d;
   logic            full, empty, push, drop, pop;

   // Full check uses the pre-edge level, so a same-edge pop cannot rescue a record.
   assign full  = (level_q == LW'(DEPTH));
   assign empty = (level_q == '0);
   assign push  = ready_in & ~full;
   assign drop  = ready_in & full;

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = StW0;
            end
         end
         StW0: if (out_ack) state_d = StW1;
         StW1: if (out_ack) state_d = StW2;
         StW2: begin
            if (out_ack) begin
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = StW0;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      entry_d = entry_q;
      if (pop) entry_d = mem[rptr_q];
      word_d  = 16'h0000;
      unique case (state_d)
         StW0:    word_d = entry_d[15:0];
         StW1:    word_d = entry_d[31:16];
         StW2:    word_d = entry_d[47:32];
         default: word_d = 16'h0000;
      endcase
      valid_d = (state_d != StIdle);
   end

   always_comb begin
      level_d = level_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      lost_d = lost_q;
      if (push)      lost_d = 1'b0;
      else if (drop) lost_d = 1'b1;

      // A drop coinciding with a clear wins over the clear.
      overflow_d = overflow_q;
      drop_d     = drop_q;
      if (drop) begin
         overflow_d = 1'b1;
         if (clear_status)          drop_d = 16'd1;
         else if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end else if (clear_status) begin
         overflow_d = 1'b0;
         drop_d     = 16'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr_q] <= {lost_q, data_in};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         wptr_q     <= '0;
         rptr_q     <= '0;
         level_q    <= '0;
         entry_q    <= '0;
         word_q     <= '0;
         valid_q    <= 1'b0;
         lost_q     <= 1'b0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         if (push) wptr_q <= wptr_q + AW'(1);
         if (pop)  rptr_q <= rptr_q + AW'(1);
         level_q    <= level_d;
         entry_q    <= entry_d;
         word_q     <= word_d;
         valid_q    <= valid_d;
         lost_q     <= lost_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end

   assign out_word   = word_q;
   assign out_valid  = valid_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_event_record_reader.sv
// Scoreboard bench for event_record_reader: expected words are queued when records are offered
// and compared as the sink accepts them.
module tb_event_record_reader;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned LW    = 5;

   logic          clk;
   logic          reset_n;
   logic [46:0]   data_in;
   logic          ready_in;
   logic [15:0]   out_word;
   logic          out_valid;
   logic          out_ack;
   logic          clear_status;
   logic          overflow;
   logic [15:0]   drop_count;
   logic [LW-1:0] fifo_level;

   event_record_reader #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .data_in      (data_in),
      .ready_in     (ready_in),
      .out_word     (out_word),
      .out_valid    (out_valid),
      .out_ack      (out_ack),
      .clear_status (clear_status),
      .overflow     (overflow),
      .drop_count   (drop_count),
      .fifo_level   (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [15:0] exp_q[$];

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Monitor: sample on the falling edge, between driving and capturing edges.
   logic        prev_hold = 1'b0;
   logic [15:0] prev_word = '0;
   int          cyc = 0;
   int          valid_cycles = 0;
   int          first_v = -1;
   int          last_v = -1;
   int          max_level = 0;

   always @(negedge clk) begin
      cyc++;
      if (reset_n) begin
         if (prev_hold) begin
            check("hold_valid", 48'(out_valid), 48'd1);
            check("hold_word", 48'(out_word), 48'(prev_word));
         end
         if (out_valid) begin
            valid_cycles++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
         end
         if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
         if (out_valid && out_ack) begin
            if (exp_q.size() == 0) check("unexpected_word_q", 48'(exp_q.size()), 48'd1);
            else check("word", 48'(out_word), 48'(exp_q.pop_front()));
         end
         prev_hold = out_valid && !out_ack;
         prev_word = out_word;
      end else begin
         prev_hold = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_expect(input logic [46:0] d, input logic lost);
      exp_q.push_back(d[15:0]);
      exp_q.push_back(d[31:16]);
      exp_q.push_back({lost, d[46:32]});
   endtask

   task automatic send(input logic [46:0] d, input bit accept, input logic lost);
      data_in  = d;
      ready_in = 1'b1;
      if (accept) push_expect(d, lost);
      tick();
      ready_in = 1'b0;
   endtask

   task automatic do_reset();
      reset_n      = 1'b0;
      ready_in     = 1'b0;
      out_ack      = 1'b0;
      clear_status = 1'b0;
      data_in      = '0;
      tick();
      exp_q.delete();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic drain(input string tag);
      out_ack = 1'b1;
      for (int i = 0; i < 300 && (exp_q.size() != 0 || out_valid); i++) tick();
      check({tag, "_drained"}, 48'(exp_q.size()), 48'd0);
      check({tag, "_idle"}, 48'(out_valid), 48'd0);
   endtask

   function automatic logic [46:0] rnd();
      return 47'({$urandom(), $urandom()});
   endfunction

   logic [46:0] rec_a;
   logic [46:0] rec_b;
   logic [0:5]  ack_pat;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rec_a   = 47'h2BCD_1234_5678;
      ack_pat = 6'b010011;

      // Reset values, sampled while reset is held
      reset_n = 1'b0; ready_in = 1'b0; out_ack = 1'b0; clear_status = 1'b0; data_in = '0;
      tick();
      check("rst_valid", 48'(out_valid), 48'd0);
      check("rst_word", 48'(out_word), 48'd0);
      check("rst_level", 48'(fifo_level), 48'd0);
      check("rst_drop", 48'(drop_count), 48'd0);
      check("rst_ovf", 48'(overflow), 48'd0);
      do_reset();

      // Single record: valid one cycle after capture, exactly three words
      out_ack = 1'b1;
      valid_cycles = 0;
      send(rec_a, 1'b1, 1'b0);
      check("single_lat0", 48'(out_valid), 48'd0);
      tick();
      check("single_lat1", 48'(out_valid), 48'd1);
      check("single_w0", 48'(out_word), 48'h5678);
      for (int i = 0; i < 6; i++) tick();
      check("single_vcycles", 48'(valid_cycles), 48'd3);
      check("single_q", 48'(exp_q.size()), 48'd0);

      // Backpressure: words held while unacknowledged
      out_ack = 1'b0;
      send(rec_a, 1'b1, 1'b0);
      tick();
      for (int i = 0; i < 6; i++) begin
         out_ack = ack_pat[i];
         tick();
      end
      out_ack = 1'b0;
      check("bp_q", 48'(exp_q.size()), 48'd0);
      tick();
      check("bp_idle", 48'(out_valid), 48'd0);

      // Overflow: 20-strobe burst without ack
      do_reset();
      for (int i = 0; i < 20; i++) send(rnd(), i < 17, 1'b0);
      tick();
      check("ovf_level", 48'(fifo_level), 48'd16);
      check("ovf_drop", 48'(drop_count), 48'd3);
      check("ovf_flag", 48'(overflow), 48'd1);
      drain("ovf");
      send(rnd(), 1'b1, 1'b1);
      drain("ovf_lost");
      check("ovf_sticky", 48'(overflow), 48'd1);

      // Clear coinciding with a drop: drop wins
      do_reset();
      for (int i = 0; i < 17; i++) send(rnd(), 1'b1, 1'b0);
      check("cd_full", 48'(fifo_level), 48'd16);
      clear_status = 1'b1;
      send(rnd(), 1'b0, 1'b0);
      clear_status = 1'b0;
      check("cd_drop", 48'(drop_count), 48'd1);
      check("cd_ovf", 48'(overflow), 48'd1);
      clear_status = 1'b1;
      tick();
      clear_status = 1'b0;
      check("clr_drop", 48'(drop_count), 48'd0);
      check("clr_ovf", 48'(overflow), 48'd0);
      drain("cd");

      // Streaming: one record every third cycle, no bubbles
      do_reset();
      out_ack = 1'b1;
      valid_cycles = 0; first_v = -1; last_v = -1; max_level = 0;
      for (int i = 0; i < 10; i++) begin
         send(rnd(), 1'b1, 1'b0);
         tick();
         tick();
      end
      for (int i = 0; i < 10; i++) tick();
      check("str_vcycles", 48'(valid_cycles), 48'd30);
      check("str_contig", 48'(last_v - first_v + 1), 48'd30);
      check("str_maxlvl_le1", 48'(max_level <= 1), 48'd1);
      check("str_drop", 48'(drop_count), 48'd0);
      check("str_q", 48'(exp_q.size()), 48'd0);

      // Mid-record reset while in W1 with a second record queued
      do_reset();
      rec_b = rnd();
      send(rec_a, 1'b1, 1'b0);
      send(rec_b, 1'b1, 1'b0);
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
      check("mid_w1", 48'(out_word), 48'h1234);
      check("mid_level", 48'(fifo_level), 48'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_valid", 48'(out_valid), 48'd0);
      check("mid_rst_level", 48'(fifo_level), 48'd0);
      exp_q.delete();
      tick();
      reset_n = 1'b1;
      tick();
      out_ack = 1'b1;
      send(rec_b, 1'b1, 1'b0);
      tick();
      check("mid_new_w0", 48'(out_word), 48'(rec_b[15:0]));
      drain("mid");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
